// File: rtl/uart_tx_scheduler_if.sv
// Core-side store port and uart launch signals of the UART transmit scheduler.
interface uart_tx_scheduler_if #(
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              stall_req;
  logic              uart_wr_o;
  logic [7:0]        uart_dat_o;
  logic [ADDR_W:0]   count;
  logic              busy;

  modport master (
    output wr_en, wr_data,
    input  stall_req, uart_wr_o, uart_dat_o, count, busy
  );

  modport slave (
    input  wr_en, wr_data,
    output stall_req, uart_wr_o, uart_dat_o, count, busy
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Queues UART store bytes and launches one per frame time, because the uart
// has no busy output.
//
// state  | meaning
// IDLE   | waiting for a queued byte; pops it on the edge to LAUNCH
// LAUNCH | uart_wr_o high for this single cycle, frame timer loaded
// WAIT   | frame timer counting down to zero, then back to IDLE
module uart_tx_scheduler #(
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4,
  parameter int FRAME_CYCLES = 8680
) (
  input  logic               sysclk,
  input  logic               nrst,
  uart_tx_scheduler_if.slave bus
);
  localparam int CNT_W = (FRAME_CYCLES > 2) ? $clog2(FRAME_CYCLES - 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  frame_cnt, frame_cnt_nxt;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] head, tail;
  logic [ADDR_W:0]   count;
  logic              wr_o;
  logic [7:0]        dat_o;
  logic              full, push, pop;

  // No bypass: a store against a full FIFO stalls even if a pop happens this edge.
  assign full          = (count == (ADDR_W+1)'(DEPTH));
  assign push          = bus.wr_en & ~full;
  assign bus.stall_req = bus.wr_en & full;

  always_comb begin
    state_nxt     = state;
    frame_cnt_nxt = frame_cnt;
    pop           = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          state_nxt = LAUNCH;
          pop       = 1'b1;
        end
      end
      LAUNCH: begin
        frame_cnt_nxt = CNT_W'(FRAME_CYCLES - 2);
        state_nxt     = WAIT;
      end
      WAIT: begin
        if (frame_cnt == '0) state_nxt = IDLE;
        else                 frame_cnt_nxt = frame_cnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      frame_cnt <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      wr_o      <= 1'b0;
      dat_o     <= '0;
    end else begin
      state     <= state_nxt;
      frame_cnt <= frame_cnt_nxt;
      wr_o      <= pop;
      if (pop) begin
        dat_o <= mem[head];
        head  <= head + 1'b1;
      end
      if (push) tail <= tail + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage has no reset; only entries between head and tail are ever read.
  always_ff @(posedge sysclk) begin
    if (push) mem[tail] <= bus.wr_data;
  end

  assign bus.uart_wr_o  = wr_o;
  assign bus.uart_dat_o = dat_o;
  assign bus.count      = count;
  assign bus.busy       = (count != '0) || (state != IDLE);
endmodule
